// File: rtl/deal_controller.sv
// Deals unique cards from a 52-card deck using an external 6-bit random source.
// Ports: clk, reset (async, active-low), rnd, req_player, req_dealer, shuffle
//   in; rng_enable, card_valid, card_to, card_idx/suit/rank/points,
//   cards_left, deck_empty, busy out.
module deal_controller #(
   parameter int unsigned MAX_TRIES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] rnd,
   input  logic       req_player,
   input  logic       req_dealer,
   input  logic       shuffle,
   output logic       rng_enable,
   output logic       card_valid,
   output logic       card_to,
   output logic [5:0] card_idx,
   output logic [1:0] card_suit,
   output logic [3:0] card_rank,
   output logic [3:0] card_points,
   output logic [5:0] cards_left,
   output logic       deck_empty,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAW,
      S_CHECK,
      S_SCAN,
      S_DELIVER
   } state_t;

   localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);
   localparam logic [5:0] DECK      = 6'd52;
   localparam logic [5:0] LAST_IDX  = 6'd51;

   state_t      state_q, state_d;
   logic [51:0] mask_q, mask_d;
   logic [5:0]  left_q, left_d;
   logic [3:0]  tries_q, tries_d;
   logic        last_q, last_d;
   logic        to_q, to_d;
   logic [5:0]  ptr_q, ptr_d;
   logic        shuf_q, shuf_d;
   logic [5:0]  idx_q, idx_d;
   logic [1:0]  suit_q, suit_d;
   logic [3:0]  rank_q, rank_d;
   logic [3:0]  points_q, points_d;

   logic [5:0]  acc_idx;
   logic [1:0]  dec_suit;
   logic [3:0]  dec_base;
   logic [3:0]  dec_rank;
   logic [3:0]  dec_points;
   logic        rnd_taken;
   logic        load;

   // Candidate index: the fresh draw in CHECK, the scan pointer otherwise.
   assign acc_idx = (state_q == S_CHECK) ? rnd : ptr_q;

   // Values 52..63 are never valid cards, so treat them as taken.
   assign rnd_taken = (rnd < DECK) ? mask_q[rnd] : 1'b1;

   always_comb begin
      dec_suit = 2'd0;
      dec_base = 4'd0;
      unique case (1'b1)
         (acc_idx >= 6'd39): begin
            dec_suit = 2'd3;
            dec_base = 4'd7;
         end
         (acc_idx >= 6'd26 && acc_idx < 6'd39): begin
            dec_suit = 2'd2;
            dec_base = 4'd10;
         end
         (acc_idx >= 6'd13 && acc_idx < 6'd26): begin
            dec_suit = 2'd1;
            dec_base = 4'd13;
         end
         (acc_idx < 6'd13): begin
            dec_suit = 2'd0;
            dec_base = 4'd0;
         end
      endcase
      // Base is the suit offset mod 16; the true remainder is < 13.
      dec_rank   = acc_idx[3:0] - dec_base + 4'd1;
      dec_points = (dec_rank > 4'd10) ? 4'd10 : dec_rank;
   end

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      left_d   = left_q;
      tries_d  = tries_q;
      last_d   = last_q;
      to_d     = to_q;
      ptr_d    = ptr_q;
      shuf_d   = shuf_q;
      idx_d    = idx_q;
      suit_d   = suit_q;
      rank_d   = rank_q;
      points_d = points_q;
      load     = 1'b0;

      if (shuffle && state_q != S_IDLE) begin
         shuf_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (shuffle || shuf_q) begin
               mask_d = '0;
               left_d = DECK;
               shuf_d = 1'b0;
            end else if (left_q != 6'd0 &&
                         (req_player || req_dealer)) begin
               to_d    = (req_player && req_dealer) ? ~last_q
                                                    : req_dealer;
               tries_d = 4'd0;
               state_d = S_DRAW;
            end
         end
         S_DRAW: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (!rnd_taken) begin
               load    = 1'b1;
               state_d = S_DELIVER;
            end else begin
               tries_d = tries_q + 4'd1;
               if (tries_d == TRIES_MAX) begin
                  ptr_d   = (rnd >= DECK) ? rnd - DECK : rnd;
                  state_d = S_SCAN;
               end else begin
                  state_d = S_DRAW;
               end
            end
         end
         S_SCAN: begin
            if (!mask_q[ptr_q]) begin
               load    = 1'b1;
               state_d = S_DELIVER;
            end else begin
               ptr_d = (ptr_q == LAST_IDX) ? 6'd0 : ptr_q + 6'd1;
            end
         end
         S_DELIVER: begin
            mask_d[idx_q] = 1'b1;
            left_d        = left_q - 6'd1;
            last_d        = to_q;
            state_d       = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Card outputs are loaded on acceptance so they are
      // already stable while card_valid is high.
      if (load) begin
         idx_d    = acc_idx;
         suit_d   = dec_suit;
         rank_d   = dec_rank;
         points_d = dec_points;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         mask_q   <= '0;
         left_q   <= DECK;
         tries_q  <= 4'd0;
         last_q   <= 1'b1;
         to_q     <= 1'b0;
         ptr_q    <= 6'd0;
         shuf_q   <= 1'b0;
         idx_q    <= 6'd0;
         suit_q   <= 2'd0;
         rank_q   <= 4'd0;
         points_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         left_q   <= left_d;
         tries_q  <= tries_d;
         last_q   <= last_d;
         to_q     <= to_d;
         ptr_q    <= ptr_d;
         shuf_q   <= shuf_d;
         idx_q    <= idx_d;
         suit_q   <= suit_d;
         rank_q   <= rank_d;
         points_q <= points_d;
      end
   end

   assign rng_enable  = (state_q == S_DRAW);
   assign card_valid  = (state_q == S_DELIVER);
   assign busy        = (state_q != S_IDLE);
   assign card_to     = to_q;
   assign card_idx    = idx_q;
   assign card_suit   = suit_q;
   assign card_rank   = rank_q;
   assign card_points = points_q;
   assign cards_left  = left_q;
   assign deck_empty  = (left_q == 6'd0);

endmodule

// File: tb/tb_deal_controller.sv
// Randomized scoreboard bench for deal_controller.
// A deck model predicts each card; a monitor checks every card_valid.
module tb_deal_controller;

   localparam int MT = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] rnd = 6'd0;
   logic       req_player = 1'b0;
   logic       req_dealer = 1'b0;
   logic       shuffle = 1'b0;
   logic       rng_enable;
   logic       card_valid;
   logic       card_to;
   logic [5:0] card_idx;
   logic [1:0] card_suit;
   logic [3:0] card_rank;
   logic [3:0] card_points;
   logic [5:0] cards_left;
   logic       deck_empty;
   logic       busy;

   deal_controller #(.MAX_TRIES(MT)) dut (
      .clk(clk),
      .reset(reset),
      .rnd(rnd),
      .req_player(req_player),
      .req_dealer(req_dealer),
      .shuffle(shuffle),
      .rng_enable(rng_enable),
      .card_valid(card_valid),
      .card_to(card_to),
      .card_idx(card_idx),
      .card_suit(card_suit),
      .card_rank(card_rank),
      .card_points(card_points),
      .cards_left(cards_left),
      .deck_empty(deck_empty),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int to;
      int idx;
      int lat;
      int pulses;
   } exp_t;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   req_cycle = 0;
   exp_t expq[$];
   int   feed[$];
   bit   dealt[52];
   int   left_m;
   int   last_m;
   bit   draw_seen = 1'b0;
   int   pulses = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic void model_clear_deck();
      for (int i = 0; i < 52; i++) dealt[i] = 1'b0;
      left_m = 52;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Random generator stub: new value the cycle after rng_enable.
   always @(negedge clk) draw_seen = rng_enable;
   always @(posedge clk) begin
      if (draw_seen) begin
         if (feed.size() > 0) rnd <= 6'(feed.pop_front());
         else rnd <= 6'($urandom_range(0, 63));
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      int   rk;
      if (!reset) begin
         pulses = 0;
      end else begin
         if (rng_enable) pulses++;
         if (card_valid) begin
            if (expq.size() == 0) begin
               chk("spurious_valid", 1, 0);
            end else begin
               e = expq.pop_front();
               rk = (e.idx % 13) + 1;
               chk("card_to", int'(card_to), e.to);
               chk("card_idx", int'(card_idx), e.idx);
               chk("card_suit", int'(card_suit), e.idx / 13);
               chk("card_rank", int'(card_rank), rk);
               chk("card_points", int'(card_points),
                   (rk > 10) ? 10 : rk);
               chk("latency", cyc - req_cycle, e.lat);
               chk("rng_pulses", pulses, e.pulses);
            end
            pulses = 0;
         end
      end
   end

   task automatic deal(input bit rp, input bit rd, input int v[4],
                       input bit shuf);
      int   k;
      int   idx;
      int   s;
      int   ptr;
      int   lat;
      int   to;
      exp_t e;
      bit   got;
      bit   sd;
      k = 0;
      idx = -1;
      for (int i = 0; i < MT; i++) begin
         k++;
         if (v[i] < 52 && !dealt[v[i]]) begin
            idx = v[i];
            break;
         end
      end
      if (idx < 0) begin
         ptr = (v[MT-1] >= 52) ? v[MT-1] - 52 : v[MT-1];
         s = 1;
         while (dealt[ptr]) begin
            ptr = (ptr + 1) % 52;
            s++;
         end
         idx = ptr;
         lat = 2 * MT + 1 + s;
      end else begin
         lat = 2 * k + 1;
      end
      to = (rp && rd) ? 1 - last_m : (rd ? 1 : 0);
      for (int i = 0; i < k; i++) feed.push_back(v[i]);
      e.to = to;
      e.idx = idx;
      e.lat = lat;
      e.pulses = k;
      expq.push_back(e);
      dealt[idx] = 1'b1;
      left_m--;
      last_m = to;

      @(negedge clk);
      req_player = rp;
      req_dealer = rd;
      req_cycle = cyc;
      got = 1'b0;
      sd = 1'b0;
      for (int t = 0; t < 300 && !got; t++) begin
         @(negedge clk);
         shuffle = 1'b0;
         if (shuf && !sd && rng_enable) begin
            shuffle = 1'b1;
            sd = 1'b1;
         end
         if (card_valid) got = 1'b1;
      end
      req_player = 1'b0;
      req_dealer = 1'b0;
      shuffle = 1'b0;
      if (!got) begin
         chk("deal_timeout", 0, 1);
         expq.delete();
         feed.delete();
      end
      @(negedge clk);
      chk("cards_left", int'(cards_left), left_m);
      chk("deck_empty", int'(deck_empty), (left_m == 0) ? 1 : 0);
      if (shuf) begin
         model_clear_deck();
         @(negedge clk);
         chk("shuffle_left", int'(cards_left), 52);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      req_player = 1'b0;
      req_dealer = 1'b0;
      shuffle = 1'b0;
      repeat (2) @(negedge clk);
      feed.delete();
      model_clear_deck();
      last_m = 1;
      reset = 1'b1;
   endtask

   initial begin : stim
      int v[4];
      int bad;
      bit got;
      bit rp;
      bit rd;
      model_clear_deck();
      last_m = 1;
      repeat (2) @(negedge clk);
      chk("rst_rng_enable", int'(rng_enable), 0);
      chk("rst_card_valid", int'(card_valid), 0);
      chk("rst_card_to", int'(card_to), 0);
      chk("rst_card_idx", int'(card_idx), 0);
      chk("rst_card_suit", int'(card_suit), 0);
      chk("rst_card_rank", int'(card_rank), 0);
      chk("rst_card_points", int'(card_points), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cards_left", int'(cards_left), 52);
      chk("rst_deck_empty", int'(deck_empty), 0);
      reset = 1'b1;

      deal(1'b1, 1'b0, '{5, 0, 0, 0}, 1'b0);
      deal(1'b1, 1'b0, '{5, 17, 0, 0}, 1'b0);

      do_reset();
      deal(1'b1, 1'b0, '{63, 63, 63, 63}, 1'b0);
      deal(1'b1, 1'b0, '{63, 63, 63, 63}, 1'b0);

      do_reset();
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 4; j++) v[j] = $urandom_range(0, 63);
         deal(1'b1, 1'b1, v, 1'b0);
      end

      do_reset();
      deal(1'b0, 1'b1, '{40, 0, 0, 0}, 1'b0);

      // Reset while the draw is being checked.
      do_reset();
      feed.push_back(9);
      @(negedge clk);
      req_player = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (rng_enable) got = 1'b1;
      end
      chk("draw_seen", int'(got), 1);
      @(negedge clk);
      reset = 1'b0;
      req_player = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_card_idx", int'(card_idx), 0);
      chk("abort_cards_left", int'(cards_left), 52);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (card_valid || rng_enable) bad++;
      end
      chk("abort_no_valid", bad, 0);
      feed.delete();
      model_clear_deck();
      last_m = 1;
      reset = 1'b1;

      deal(1'b1, 1'b0, '{20, 0, 0, 0}, 1'b1);
      deal(1'b0, 1'b1, '{20, 0, 0, 0}, 1'b0);

      // Randomized deals until the deck is exhausted.
      do_reset();
      while (left_m > 0) begin
         rp = 1'($urandom_range(0, 1));
         rd = rp ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int j = 0; j < 4; j++) v[j] = $urandom_range(0, 63);
         deal(rp, rd, v, 1'b0);
      end
      chk("empty_flag", int'(deck_empty), 1);
      chk("empty_left", int'(cards_left), 0);
      @(negedge clk);
      req_player = 1'b1;
      req_dealer = 1'b1;
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (rng_enable || card_valid || busy) bad++;
      end
      chk("empty_ignores_req", bad, 0);
      req_player = 1'b0;
      req_dealer = 1'b0;
      @(negedge clk);
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      chk("reshuffle_left", int'(cards_left), 52);
      chk("reshuffle_empty", int'(deck_empty), 0);
      model_clear_deck();
      for (int j = 0; j < 4; j++) v[j] = $urandom_range(0, 63);
      deal(1'b1, 1'b0, v, 1'b0);

      repeat (3) @(negedge clk);
      chk("expq_drained", expq.size(), 0);
      chk("feed_drained", feed.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/deal_controller.md
Name: deal_controller

Overview:
- Sequences the 6-bit pseudo-random generator to deal unique cards from a 52-card deck.
- Arbitrates deals between the player and the dealer requester, requests fresh random values, rejects out-of-range or already-dealt values, and guarantees termination with a fallback scan.
- Tracks the dealt-card set and delivers the decoded card: index, suit, rank and points.
- Sits between the random generator and the game FSM.

Parameters:
- MAX_TRIES, 4: rejected random draws allowed per deal before switching to linear scan (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rnd  in  6  random value from the generator; registered, updates the cycle after rng_enable.
- req_player  in  1  player wants a card; level, held until ack.
- req_dealer  in  1  dealer wants a card; level, held until ack.
- shuffle  in  1  single-cycle pulse; returns all 52 cards to the deck.
- rng_enable  out  1  advance the generator this cycle.
- card_valid  out  1  one-cycle pulse; card outputs are new; acts as ack.
- card_to  out  1  recipient of the current card: 0 = player, 1 = dealer.
- card_idx  out  6  card index, 0..51.
- card_suit  out  2  card_idx / 13.
- card_rank  out  4  (card_idx % 13) + 1; 1 = Ace ... 13 = King.
- card_points  out  4  rank capped at 10; Ace = 1.
- cards_left  out  6  undealt card count, 0..52.
- deck_empty  out  1  high when cards_left == 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset = 0, async):
  - State IDLE; deck mask all-unused; cards_left = 52; tries = 0; last_served = dealer.
  - All other outputs 0: rng_enable, card_valid, card_to, card_idx, card_suit, card_rank, card_points, busy.
  - Reset mid-deal abandons the deal with no card_valid; the deck returns to full.
- States:
  - IDLE:
    - Pending shuffle (input pulse or latched flag) has top priority: clear mask, cards_left = 52, clear flag, stay IDLE.
    - Else, if deck_empty: ignore requests.
    - Else, if any request: grant and go to DRAW.
      - Only one requester: that one.
      - Both: the one not equal to last_served (round-robin).
      - Latch the grant into card_to; tries = 0.
  - DRAW: rng_enable = 1 for exactly this cycle; go to CHECK.
  - CHECK: sample rnd.
    - Accept if rnd < 52 and mask[rnd] == 0: record index, go to DELIVER.
    - Otherwise reject: tries += 1.
      - If tries reaches MAX_TRIES: scan pointer = (rnd >= 52) ? rnd - 52 : rnd; go to SCAN.
      - Else go to DRAW.
  - SCAN: test one index per cycle.
    - If mask[ptr] == 0: accept ptr, go to DELIVER.
    - Else ptr += 1, wrapping 51 -> 0.
    - Always terminates within 52 cycles, since cards_left > 0 at grant.
  - DELIVER:
    - Register outputs: card_idx, suit, rank, points.
    - Set mask[idx]; cards_left -= 1; last_served = card_to.
    - card_valid = 1 for this one cycle; return to IDLE.
- Card outputs hold their last value until the next DELIVER.
- Latency: a request seen in IDLE at cycle 0 gives DRAW at 1, CHECK at 2, card_valid at 3. Each rejected draw adds 2 cycles; each scan step adds 1.
- A requester must drop its request in the cycle after card_valid. A request still high in IDLE is treated as a new request.
- Requests dropped after grant: the card is still delivered.
- Shuffle while busy: latched, applied on the first IDLE cycle after DELIVER. The in-flight card still counts against the old deck and is then returned.
- Shuffle and request in the same IDLE cycle: shuffle first; the request is granted the following cycle.
- rnd is ignored outside CHECK.
- busy = (state != IDLE).

Test Plan:
- Reset, rnd stub = 5, req_player high -> card_valid at cycle 3, card_to = 0, card_idx = 5, suit = 0, rank = 6, points = 6, cards_left = 51, exactly one rng_enable pulse.
- Duplicate: second req_player, rnd = 5 then 17 -> one rejection, 2 rng_enable pulses, card_idx = 17, suit = 1, rank = 5, card_valid at cycle 5.
- Out of range: rnd held at 63, MAX_TRIES = 4, deck full -> 4 rejections, scan starts at 11, card_idx = 11, rank = 12, points = 10. With card 11 already dealt -> card_idx = 12.
- Arbitration: req_player and req_dealer both held -> first card to player, second to dealer, third to player. Dealer alone after reset -> served immediately.
- Exhaustion: deal 52 cards -> cards_left = 0, deck_empty = 1, further requests produce no rng_enable and no card_valid. shuffle pulse -> cards_left = 52, deck_empty = 0.
- Disruption:
  - reset asserted in CHECK -> no card_valid, outputs zero, cards_left = 52.
  - shuffle pulsed in DRAW -> card still delivered, then cards_left = 52 the following cycle.
